mac_dot_stream: RTL and testbench

Streaming dot-product engine for the matrix-multiply datapath: accepts one (a, b) element pair per cycle over a valid/ready handshake, multiplies and accumulates them, and returns one dot product per vector framed by `in_last`. It generalises the fixed-width string/column MAC with variable vector length up to `MAX_LEN`, a per-vector signed/unsigned mode, overflow-free guard bits, length-error detection and output back-pressure. One instance computes one result-matrix element stream; the matrix controller feeds rows and columns as vectors.

---
 rtl/mac_dot_stream_if.sv | 37 +++
 rtl/mac_dot_stream.sv | 150 +++++++++++++++
 tb/tb_mac_dot_stream.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_dot_stream_if.sv
// ============================================================================
// mac_dot_stream_if : operand-in / result-out handshake bundle
// Rev 1.0
// ============================================================================
`default_nettype none

interface mac_dot_stream_if #(
  parameter int BITS    = 24,
  parameter int MAX_LEN = 16
);
  localparam int ACC_W = 2*BITS + $clog2(MAX_LEN);
  localparam int CNT_W = $clog2(MAX_LEN + 1);

  logic             in_valid;
  logic             in_ready;
  logic [BITS-1:0]  in_a;
  logic [BITS-1:0]  in_b;
  logic             in_last;
  logic             in_signed;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_result;
  logic [CNT_W-1:0] out_count;
  logic             out_len_err;

  modport master (
    output in_valid, in_a, in_b, in_last, in_signed, out_ready,
    input  in_ready, out_valid, out_result, out_count, out_len_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_last, in_signed, out_ready,
    output in_ready, out_valid, out_result, out_count, out_len_err
  );
endinterface

`default_nettype wire

// File: rtl/mac_dot_stream.sv
// ============================================================================
// mac_dot_stream : streaming multiply-accumulate dot-product engine
// Rev 1.0
// ============================================================================
`default_nettype none

module mac_dot_stream #(
  parameter int BITS    = 24,
  parameter int MAX_LEN = 16
) (
  input  logic              clk,
  input  logic              reset,
  mac_dot_stream_if.slave   bus
);
  localparam int ACC_W = 2*BITS + $clog2(MAX_LEN);
  localparam int CNT_W = $clog2(MAX_LEN + 1);
  localparam int PW    = 2*BITS;
  localparam int GW    = ACC_W - PW;

  typedef enum logic [1:0] {
    ST_ACC   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_OUT   = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    p_q, p_d;
  logic             p_valid_q, p_valid_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             signed_q, signed_d;
  logic             len_err_q, len_err_d;
  logic [ACC_W-1:0] result_q, result_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             out_len_err_q, out_len_err_d;

  logic             w_accept;
  logic             w_first;
  logic             w_mode;
  logic             w_terminal;
  logic [PW-1:0]    w_a_ext;
  logic [PW-1:0]    w_b_ext;
  logic [PW-1:0]    w_prod;
  logic [ACC_W-1:0] w_p_ext;
  logic [ACC_W-1:0] w_acc_sum;

  // The first beat uses in_signed directly; later beats use the latched mode.
  assign w_accept   = bus.in_valid && in_ready_q;
  assign w_first    = (cnt_q == '0);
  assign w_mode     = w_first ? bus.in_signed : signed_q;
  assign w_terminal = bus.in_last || (cnt_q == CNT_W'(MAX_LEN - 1));
  assign w_a_ext    = {{BITS{w_mode & bus.in_a[BITS-1]}}, bus.in_a};
  assign w_b_ext    = {{BITS{w_mode & bus.in_b[BITS-1]}}, bus.in_b};
  assign w_prod     = w_a_ext * w_b_ext;
  assign w_p_ext    = {{GW{signed_q & p_q[PW-1]}}, p_q};
  assign w_acc_sum  = acc_q + w_p_ext;

  always_comb begin
    state_d       = state_q;
    in_ready_d    = in_ready_q;
    out_valid_d   = out_valid_q;
    p_d           = w_accept ? w_prod : p_q;
    p_valid_d     = w_accept;
    acc_d         = acc_q;
    cnt_d         = cnt_q;
    signed_d      = signed_q;
    len_err_d     = len_err_q;
    result_d      = result_q;
    count_d       = count_q;
    out_len_err_d = out_len_err_q;

    unique case (state_q)
      ST_ACC: begin
        if (p_valid_q) acc_d = w_acc_sum;
        if (w_accept) begin
          cnt_d = cnt_q + 1'b1;
          if (w_first) signed_d = bus.in_signed;
          if (w_terminal) begin
            state_d    = ST_DRAIN;
            in_ready_d = 1'b0;
            len_err_d  = !bus.in_last;
          end
        end
      end
      ST_DRAIN: begin
        result_d      = w_acc_sum;
        count_d       = cnt_q;
        out_len_err_d = len_err_q;
        acc_d         = '0;
        cnt_d         = '0;
        len_err_d     = 1'b0;
        out_valid_d   = 1'b1;
        state_d       = ST_OUT;
      end
      ST_OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          in_ready_d  = 1'b1;
          state_d     = ST_ACC;
        end
      end
      default: begin
        state_d     = ST_ACC;
        in_ready_d  = 1'b1;
        out_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= ST_ACC;
      in_ready_q    <= 1'b1;
      out_valid_q   <= 1'b0;
      p_q           <= '0;
      p_valid_q     <= 1'b0;
      acc_q         <= '0;
      cnt_q         <= '0;
      signed_q      <= 1'b0;
      len_err_q     <= 1'b0;
      result_q      <= '0;
      count_q       <= '0;
      out_len_err_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      in_ready_q    <= in_ready_d;
      out_valid_q   <= out_valid_d;
      p_q           <= p_d;
      p_valid_q     <= p_valid_d;
      acc_q         <= acc_d;
      cnt_q         <= cnt_d;
      signed_q      <= signed_d;
      len_err_q     <= len_err_d;
      result_q      <= result_d;
      count_q       <= count_d;
      out_len_err_q <= out_len_err_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_result  = result_q;
  assign bus.out_count   = count_q;
  assign bus.out_len_err = out_len_err_q;

endmodule

`default_nettype wire

// File: tb/tb_mac_dot_stream.sv
// ============================================================================
// tb_mac_dot_stream : scoreboard bench with an arithmetic dot-product model
// Rev 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_mac_dot_stream;
  localparam int BITS    = 24;
  localparam int MAX_LEN = 16;
  localparam int ACC_W   = 2*BITS + $clog2(MAX_LEN);
  localparam int CNT_W   = $clog2(MAX_LEN + 1);

  typedef struct {
    logic [ACC_W-1:0] res;
    logic [CNT_W-1:0] cnt;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mac_dot_stream_if #(.BITS(BITS), .MAX_LEN(MAX_LEN)) bus();

  mac_dot_stream #(.BITS(BITS), .MAX_LEN(MAX_LEN)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t   exp_q[$];
  int     term_q[$];
  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  bit     bp_hold = 1'b0;
  bit     rand_ready = 1'b0;
  longint m_acc = 0;
  int     m_cnt = 0;
  bit     m_sgn = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Reference: plain integer dot product, truncated at MAX_LEN beats.
  task automatic model_beat(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                            input bit last, input bit sgn);
    longint va, vb;
    exp_t   e;
    logic [63:0] full;
    if (m_cnt == 0) m_sgn = sgn;
    va = m_sgn ? longint'($signed(a)) : longint'(a);
    vb = m_sgn ? longint'($signed(b)) : longint'(b);
    m_acc += va * vb;
    m_cnt++;
    if (last || m_cnt == MAX_LEN) begin
      full  = m_acc;
      e.res = full[ACC_W-1:0];
      e.cnt = CNT_W'(m_cnt);
      e.err = !last;
      exp_q.push_back(e);
      term_q.push_back(cyc);
      m_acc = 0;
      m_cnt = 0;
    end
  endtask

  task automatic send_beat(input logic [BITS-1:0] a, input logic [BITS-1:0] b,
                           input bit last, input bit sgn);
    int n = 0;
    bus.in_valid  = 1'b1;
    bus.in_a      = a;
    bus.in_b      = b;
    bus.in_last   = last;
    bus.in_signed = sgn;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 200) begin
        chk("accept_timeout", 64'd0, 64'd1);
        bus.in_valid = 1'b0;
        return;
      end
    end
    model_beat(a, b, last, sgn);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic apply_reset();
    bus.in_valid = 1'b0;
    #2 reset = 1'b0;
    exp_q.delete();
    term_q.delete();
    m_acc = 0;
    m_cnt = 0;
    #1;
    chk("rst_in_ready", 64'(bus.in_ready), 64'd1);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_result", 64'(bus.out_result), 64'd0);
    chk("rst_count_err", 64'({bus.out_count, bus.out_len_err}), 64'd0);
    repeat (2) @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic wait_out_valid();
    int n = 0;
    while (!bus.out_valid && n < 50) begin @(negedge clk); n++; end
    if (!bus.out_valid) chk("out_valid_timeout", 64'd0, 64'd1);
  endtask

  task automatic send_rand_vec(input int len, input bit sgn, input bit bubbles);
    for (int i = 0; i < len; i++) begin
      send_beat(BITS'($urandom), BITS'($urandom), i == len - 1, sgn);
      if (bubbles && $urandom_range(0, 3) == 0) idle($urandom_range(1, 3));
    end
  endtask

  initial begin
    bus.out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      bus.out_ready = bp_hold ? 1'b0 : (rand_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    end
  end

  // Monitor: handshake results, latency, hold stability and in_ready rules.
  bit               ov_prev = 1'b0;
  bit               hs_prev = 1'b0;
  logic [ACC_W-1:0] held_res;
  logic [CNT_W:0]   held_ce;
  always @(negedge clk) begin
    bit   hs;
    exp_t e;
    hs = 1'b0;
    if (reset) begin
      if (hs_prev) chk("in_ready_after_hs", 64'(bus.in_ready), 64'd1);
      if (bus.out_valid) begin
        chk("in_ready_in_out", 64'(bus.in_ready), 64'd0);
        if (!ov_prev) begin
          if (term_q.size() == 0) chk("unexpected_out_valid", 64'd1, 64'd0);
          else chk("latency", 64'(cyc - term_q.pop_front()), 64'd2);
        end else if (!hs_prev) begin
          chk("hold_result", 64'(bus.out_result), 64'(held_res));
          chk("hold_count_err", 64'({bus.out_count, bus.out_len_err}), 64'(held_ce));
        end
        held_res = bus.out_result;
        held_ce  = {bus.out_count, bus.out_len_err};
        if (bus.out_ready) begin
          hs = 1'b1;
          if (exp_q.size() == 0) chk("unexpected_result", 64'd1, 64'd0);
          else begin
            e = exp_q.pop_front();
            chk("result", 64'(bus.out_result), 64'(e.res));
            chk("count", 64'(bus.out_count), 64'(e.cnt));
            chk("len_err", 64'(bus.out_len_err), 64'(e.err));
          end
        end
      end
      ov_prev = bus.out_valid;
      hs_prev = hs;
    end else begin
      ov_prev = 1'b0;
      hs_prev = 1'b0;
    end
  end

  initial begin
    int n;
    bus.in_valid  = 1'b0;
    bus.in_a      = '0;
    bus.in_b      = '0;
    bus.in_last   = 1'b0;
    bus.in_signed = 1'b0;
    #12;
    apply_reset();

    send_beat(24'd1, 24'd2, 1'b0, 1'b0);
    send_beat(24'd3, 24'd4, 1'b0, 1'b0);
    send_beat(24'd5, 24'd6, 1'b1, 1'b0);
    idle(4);

    send_beat(24'hFFFFFD, 24'd7, 1'b0, 1'b1);
    send_beat(24'd2, 24'hFFFFFB, 1'b0, 1'b0);
    send_beat(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b0);
    send_beat(24'hFFFFFD, 24'd7, 1'b0, 1'b0);
    send_beat(24'd2, 24'hFFFFFB, 1'b0, 1'b1);
    send_beat(24'hFFFFFF, 24'hFFFFFF, 1'b1, 1'b1);

    for (int i = 0; i < MAX_LEN; i++) send_beat(24'hFFFFFF, 24'hFFFFFF, i == MAX_LEN - 1, 1'b0);
    for (int i = 0; i < MAX_LEN; i++) send_beat(24'h800000, 24'h800000, i == MAX_LEN - 1, 1'b1);
    for (int i = 0; i < 18; i++) send_beat(24'd1, 24'd1, i == 17, 1'b0);
    idle(4);

    bp_hold = 1'b1;
    send_beat(24'd7, 24'd8, 1'b1, 1'b0);
    wait_out_valid();
    bus.in_valid = 1'b1;
    bus.in_a     = 24'd9;
    bus.in_b     = 24'd9;
    bus.in_last  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_in_ready_low", 64'(bus.in_ready), 64'd0);
    end
    bp_hold = 1'b0;
    send_beat(24'd9, 24'd9, 1'b1, 1'b0);

    rand_ready = 1'b1;
    for (int v = 0; v < 40; v++) send_rand_vec($urandom_range(1, 20), 1'($urandom_range(0, 1)), 1'b1);
    rand_ready = 1'b0;
    idle(10);

    send_rand_vec(1, 1'b0, 1'b0);
    send_beat(24'd5, 24'd5, 1'b0, 1'b0);
    idle(2);
    send_beat(24'd6, 24'd6, 1'b0, 1'b0);
    send_beat(24'd7, 24'd7, 1'b0, 1'b0);
    apply_reset();
    send_beat(24'd2, 24'd2, 1'b1, 1'b0);
    idle(6);

    bp_hold = 1'b1;
    send_beat(24'd3, 24'd3, 1'b1, 1'b1);
    wait_out_valid();
    @(posedge clk); #1;
    apply_reset();
    bp_hold = 1'b0;
    idle(3);
    send_beat(24'd2, 24'd2, 1'b1, 1'b0);

    n = 0;
    while (exp_q.size() != 0 && n < 500) begin @(posedge clk); n++; end
    idle(3);
    chk("results_drained", 64'(exp_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
